// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM state encoding and byte-order helper for the SPI flash reader.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  typedef enum logic [2:0] {
    S_WAKE_CMD,
    S_WAKE_WAIT,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_e;

  // Flash streams bytes in ascending address order; the first byte becomes the LSB.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: SCK divider, bit counter and a 32-bit TX/RX shifter.
// done_o is asserted in the cycle whose closing edge drops SCK after the final bit.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  len_i,
  input  logic [31:0] tx_i,
  input  logic        freeze_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        active_o,
  output logic        done_o,
  output logic [31:0] rx_o
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic        active_q, active_d;
  logic        sck_q, sck_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        tick;
  logic        last_bit;

  assign tick     = active_q && !freeze_i && (div_q == DIV_MAX);
  assign last_bit = (cnt_q == len_q - 6'd1);
  assign done_o   = tick && sck_q && last_bit;
  assign sck_o    = sck_q;
  assign mosi_o   = tx_q[31];
  assign active_o = active_q;
  assign rx_o     = rx_q;

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    // A start in the same cycle as done chains the next field with no idle SCK period.
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      cnt_d    = '0;
      len_d    = len_i;
      tx_d     = tx_i;
    end else if (active_q && !freeze_i) begin
      if (tick) begin
        div_d = '0;
        sck_d = !sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[30:0], miso_i};
        end else begin
          tx_d  = {tx_q[30:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (last_bit) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash burst reader: wakes the flash with 0xAB, then serves READ (0x03) bursts
// as little-endian 32-bit words on a valid/ready stream with a 1-entry output register.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CS_GAP      = 4,
  parameter int WAKE_CYCLES = 64,
  parameter int LEN_W       = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1
);

  localparam logic [15:0]      WAKE_LIMIT = 16'(WAKE_CYCLES);
  localparam logic [15:0]      GAP_LIMIT  = 16'(CS_GAP - 1);
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             csb_q, csb_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;

  logic        eng_start, eng_active, eng_done;
  logic [5:0]  eng_len;
  logic [31:0] eng_tx, eng_rx;
  logic        rsp_free, is_last, take_word;

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .start_i  (eng_start),
    .len_i    (eng_len),
    .tx_i     (eng_tx),
    .freeze_i (state_q == S_HOLD),
    .miso_i   (flash_io1),
    .sck_o    (flash_clk),
    .mosi_o   (flash_io0),
    .active_o (eng_active),
    .done_o   (eng_done),
    .rx_o     (eng_rx)
  );

  assign rsp_free  = !rsp_valid_q || rsp_ready;
  assign is_last   = (rem_q == LEN_ONE);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign flash_csb = csb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

  always_comb begin
    state_d     = state_q;
    csb_d       = csb_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    eng_start   = 1'b0;
    eng_len     = 6'd32;
    eng_tx      = '0;
    take_word   = 1'b0;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      S_WAKE_CMD: begin
        if (!eng_active) begin
          eng_start = 1'b1;
          eng_len   = 6'd8;
          eng_tx    = {CMD_WAKE, 24'h0};
          csb_d     = 1'b0;
        end
        if (eng_done) begin
          csb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAKE_WAIT;
        end
      end
      S_WAKE_WAIT: begin
        if (cnt_q == WAKE_LIMIT) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          rem_d   = (req_len == '0) ? LEN_ONE : req_len;
          csb_d   = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!eng_active) begin
          eng_start = 1'b1;
          eng_len   = 6'd8;
          eng_tx    = {CMD_READ, 24'h0};
        end
        if (eng_done) begin
          eng_start = 1'b1;
          eng_len   = 6'd24;
          eng_tx    = {addr_q, 8'h0};
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (eng_done) begin
          eng_start = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (eng_done) begin
          if (rsp_free) take_word = 1'b1;
          else          state_d   = S_HOLD;
        end
      end
      S_HOLD: take_word = rsp_free;
      S_GAP: begin
        if (cnt_q == GAP_LIMIT) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_WAKE_CMD;
    endcase

    // Word leaves the shifter; either chain the next word or close the transaction.
    if (take_word) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bswap32(eng_rx);
      rsp_last_d  = is_last;
      rem_d       = rem_q - LEN_ONE;
      if (is_last) begin
        csb_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_GAP;
      end else begin
        eng_start = 1'b1;
        state_d   = S_DATA;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_WAKE_CMD;
      csb_q       <= 1'b1;
      cnt_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      csb_q       <= csb_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a small behavioural SPI flash (mem[i] = i).
module tb_spi_flash_reader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;

  spi_flash_reader dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge wb_clk_i) cyc++;

  // Flash model: per csb-low window, count SCK pulses and log MOSI; serve bytes after 32 bits.
  logic [7:0]  mem [256];
  int          bitn = 0;
  int          pulses = 0;
  logic [63:0] mosi_log = '0;
  logic [23:0] faddr = '0;
  int          idx;
  logic [7:0]  fbyte;

  always @(posedge flash_clk or negedge flash_csb) begin
    if (!flash_clk) begin
      bitn = 0;
      pulses = 0;
      mosi_log = '0;
    end else if (!flash_csb) begin
      if (bitn >= 8 && bitn < 32) faddr = {faddr[22:0], flash_io0};
      mosi_log = {mosi_log[62:0], flash_io0};
      pulses++;
      bitn++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && bitn >= 32) begin
      idx = bitn - 32;
      fbyte = mem[8'(faddr[7:0] + 8'(idx / 8))];
      flash_io1 = fbyte[3'(7 - idx % 8)];
    end
  end

  logic [31:0] got [8];
  logic        gotlast [8];
  int          gotcyc [8];
  int          nwords;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_csb(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (flash_csb !== lvl && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(tag, 32'(flash_csb), 32'(lvl));
  endtask

  task automatic check_wake();
    int n = 0;
    wait_csb(1'b0, 20, "wake_csb_low");
    wait_csb(1'b1, 200, "wake_csb_high");
    chk("wake_pulses", pulses, 8);
    chk("wake_mosi", 32'(mosi_log[7:0]), 32'h0000_00AB);
    while (!req_ready && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("wake_ready_delay", n, 65);
  endtask

  task automatic do_req(input logic [23:0] a, input logic [7:0] l);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    $display("txn: read addr=%06h len=%0d at cycle %0d", a, l, cyc);
    req_addr = a;
    req_len = l;
    req_valid = 1'b1;
    @(negedge wb_clk_i);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int budget);
    nwords = 0;
    repeat (budget) begin
      if (rsp_valid && rsp_ready && nwords < 8) begin
        got[nwords] = rsp_data;
        gotlast[nwords] = rsp_last;
        gotcyc[nwords] = cyc;
        nwords++;
      end
      @(negedge wb_clk_i);
    end
  endtask

  logic [31:0] exp10 [4];
  initial begin
    exp10[0] = 32'h1312_1110;
    exp10[1] = 32'h1716_1514;
    exp10[2] = 32'h1B1A_1918;
    exp10[3] = 32'h1F1E_1D1C;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w0, hold_word;
    logic seen, clk450, csb450;
    int unstable, p300, p499;
    int hs, viol, run, min_gap, nw, bad;
    logic started;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset values
    #2 wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_csb", 32'(flash_csb), 32'd1);
    chk("rst_sck", 32'(flash_clk), 32'd0);
    chk("rst_io0", 32'(flash_io0), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    wb_rst_i = 1'b0;

    // Wake command and wait
    check_wake();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single-word read at 0
    rsp_ready = 1'b1;
    do_req(24'h000000, 8'd1);
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("single_latency", n, 258);
    chk("single_data", rsp_data, 32'h0302_0100);
    chk("single_last", 32'(rsp_last), 32'd1);
    chk("single_csb_high", 32'(flash_csb), 32'd1);
    chk("single_pulses", pulses, 64);
    chk("single_mosi_cmd_addr", mosi_log[63:32], 32'h0300_0000);
    chk("single_mosi_data", mosi_log[31:0], 32'h0000_0000);
    @(negedge wb_clk_i);
    chk("single_consumed", 32'(rsp_valid), 32'd0);

    // Burst of 4 with no backpressure
    do_req(24'h000010, 8'd4);
    collect(700);
    chk("burst_count", nwords, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("burst_data%0d", k), got[k], exp10[k]);
      chk($sformatf("burst_last%0d", k), 32'(gotlast[k]), (k == 3) ? 32'd1 : 32'd0);
      if (k > 0) chk($sformatf("burst_spacing%0d", k), gotcyc[k] - gotcyc[k-1], 128);
    end

    // Same burst with a 500-cycle stall after the first word
    do_req(24'h000010, 8'd4);
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    w0 = rsp_data;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    seen = 1'b0; unstable = 0; p300 = -1; p499 = -2; clk450 = 1'bx; csb450 = 1'bx;
    hold_word = '0;
    for (int i = 0; i < 500; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        if (!seen) begin
          hold_word = rsp_data;
          seen = 1'b1;
        end else if (rsp_data !== hold_word) begin
          unstable++;
        end
      end
      if (i == 300) p300 = pulses;
      if (i == 450) begin
        clk450 = flash_clk;
        csb450 = flash_csb;
      end
      if (i == 499) p499 = pulses;
    end
    chk("stall_first_word", w0, exp10[0]);
    chk("stall_seen", 32'(seen), 32'd1);
    chk("stall_held_word", hold_word, exp10[1]);
    chk("stall_data_stable", unstable, 0);
    chk("stall_sck_frozen", p499, p300);
    chk("stall_sck_low", 32'(clk450), 32'd0);
    chk("stall_csb_low", 32'(csb450), 32'd0);
    rsp_ready = 1'b1;
    collect(600);
    chk("stall_rest_count", nwords, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_data%0d", k + 1), got[k], exp10[k+1]);
      chk($sformatf("stall_last%0d", k + 1), 32'(gotlast[k]), (k == 2) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of the address phase
    do_req(24'h000020, 8'd2);
    repeat (50) @(negedge wb_clk_i);
    chk("pre_reset_csb", 32'(flash_csb), 32'd0);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("abort_csb", 32'(flash_csb), 32'd1);
    chk("abort_sck", 32'(flash_clk), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_wake();
    do_req(24'h000020, 8'd2);
    collect(450);
    chk("post_reset_count", nwords, 2);
    chk("post_reset_data0", got[0], 32'h2322_2120);
    chk("post_reset_data1", got[1], 32'h2726_2524);
    chk("post_reset_last0", 32'(gotlast[0]), 32'd0);
    chk("post_reset_last1", 32'(gotlast[1]), 32'd1);

    // Back-to-back requests with req_valid held high; len 0 reads one word
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    $display("txn: back-to-back reads addr=000030 len=0 from cycle %0d", cyc);
    req_addr = 24'h000030;
    req_len = 8'd0;
    req_valid = 1'b1;
    hs = 0; viol = 0; run = 0; min_gap = 999; nw = 0; bad = 0; started = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (req_valid && req_ready) hs++;
      if (req_ready && !flash_csb) viol++;
      if (!flash_csb) begin
        if (started && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        started = 1'b1;
      end else begin
        run++;
      end
      if (rsp_valid && rsp_ready) begin
        nw++;
        if (rsp_data !== 32'h3332_3130 || rsp_last !== 1'b1) bad++;
      end
      @(negedge wb_clk_i);
    end
    req_valid = 1'b0;
    collect(400);
    for (int k = 0; k < nwords; k++) begin
      if (got[k] !== 32'h3332_3130 || gotlast[k] !== 1'b1) bad++;
    end
    nw += nwords;
    chk("b2b_handshakes_ge3", 32'(hs >= 3), 32'd1);
    chk("b2b_words_eq_requests", nw, hs);
    chk("b2b_word_errors", bad, 0);
    chk("b2b_ready_during_txn", viol, 0);
    chk("b2b_gap_ge_cs_gap", 32'(min_gap >= 4 && min_gap < 999), 32'd1);
    chk("b2b_final_idle", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
